// File: rtl/spi_slave_shift_engine.sv
// SPI slave data path for one chip-select lane: pclk-oversampled sclk/cs/mosi0,
// CPOL/CPHA edge selection, LSB-first receive and transmit with a one-word holding buffer.
module spi_slave_shift_engine #(
  parameter int NO_OF_SLAVES = 1,
  parameter int SLAVE_ID     = 0,
  parameter int CHAR_LENGTH  = 8,
  parameter bit CPOL         = 1'b0,
  parameter bit CPHA         = 1'b0
) (
  input  logic                    pclk,
  input  logic                    areset,
  input  logic                    sclk,
  input  logic [NO_OF_SLAVES-1:0] cs,
  input  logic                    mosi0,
  output logic                    miso0,
  input  logic [CHAR_LENGTH-1:0]  tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [CHAR_LENGTH-1:0]  rx_data,
  output logic                    rx_valid,
  output logic                    tx_underrun,
  output logic                    frame_err
);

  localparam int CW = $clog2(CHAR_LENGTH);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                 state_reg, state_next;
  logic [2:0]             sclk_sync_reg;
  logic [2:0]             cs_sync_reg;
  logic [1:0]             mosi_sync_reg;
  logic [CW-1:0]          bit_cnt_reg, bit_cnt_next;
  logic [CHAR_LENGTH-1:0] rx_shift_reg, rx_shift_next;
  logic [CHAR_LENGTH-1:0] tx_shift_reg, tx_shift_next;
  logic [CHAR_LENGTH-1:0] buf_reg, buf_next;
  logic                   buf_full_reg, buf_full_next;
  logic [CHAR_LENGTH-1:0] rx_data_reg, rx_data_next;
  logic                   rx_valid_reg, rx_valid_next;
  logic                   underrun_reg, underrun_next;
  logic                   frame_err_reg, frame_err_next;
  logic                   miso_reg, miso_next;

  logic sclk_rise, sclk_fall, leading_edge, trailing_edge;
  logic sample_edge, shift_edge, cs_fall, cs_rise, mosi_s;
  logic word_done, load, buf_write;
  logic [CHAR_LENGTH-1:0] rx_assembled;
  logic cs_unused;

  // Only cs[SLAVE_ID] matters; the reduction just marks the other lanes as deliberately ignored.
  assign cs_unused = ^cs;

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      sclk_sync_reg <= {3{CPOL}};
      cs_sync_reg   <= 3'b111;
      mosi_sync_reg <= 2'b00;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[1:0], sclk};
      cs_sync_reg   <= {cs_sync_reg[1:0], cs[SLAVE_ID]};
      mosi_sync_reg <= {mosi_sync_reg[0], mosi0};
    end
  end

  assign sclk_rise     = sclk_sync_reg[1] & ~sclk_sync_reg[2];
  assign sclk_fall     = ~sclk_sync_reg[1] & sclk_sync_reg[2];
  assign leading_edge  = CPOL ? sclk_fall : sclk_rise;
  assign trailing_edge = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge   = CPHA ? trailing_edge : leading_edge;
  assign shift_edge    = CPHA ? leading_edge : trailing_edge;
  assign cs_fall       = ~cs_sync_reg[1] & cs_sync_reg[2];
  assign cs_rise       = cs_sync_reg[1] & ~cs_sync_reg[2];
  assign mosi_s        = mosi_sync_reg[1];

  assign word_done = (state_reg == ACTIVE) && sample_edge &&
                     (bit_cnt_reg == CW'(CHAR_LENGTH - 1));
  assign buf_write = tx_valid & ~buf_full_reg;

  always_comb begin
    rx_assembled              = rx_shift_reg;
    rx_assembled[bit_cnt_reg] = mosi_s;
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cs_fall) state_next = ACTIVE;
      ACTIVE:  if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_next   = bit_cnt_reg;
    rx_shift_next  = rx_shift_reg;
    tx_shift_next  = tx_shift_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    underrun_next  = 1'b0;
    frame_err_next = 1'b0;
    miso_next      = miso_reg;
    load           = 1'b0;
    case (state_reg)
      IDLE: begin
        miso_next = 1'b0;
        if (cs_fall) begin
          load         = 1'b1;
          bit_cnt_next = '0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // A final sample arriving with the cs release still completes the word.
          miso_next      = 1'b0;
          bit_cnt_next   = '0;
          tx_shift_next  = '0;
          frame_err_next = (bit_cnt_reg != '0) && !word_done;
          if (word_done) begin
            rx_data_next  = rx_assembled;
            rx_valid_next = 1'b1;
          end
        end else begin
          if (sample_edge) begin
            rx_shift_next = rx_assembled;
            if (word_done) begin
              bit_cnt_next  = '0;
              rx_data_next  = rx_assembled;
              rx_valid_next = 1'b1;
              load          = 1'b1;
            end else begin
              bit_cnt_next = bit_cnt_reg + CW'(1);
            end
          end
          if (shift_edge) begin
            // With CPHA=0 a zero count means a fresh word already sits on miso0.
            if (CPHA) begin
              miso_next     = tx_shift_reg[0];
              tx_shift_next = tx_shift_reg >> 1;
            end else if (bit_cnt_reg != '0) begin
              miso_next     = tx_shift_reg[1];
              tx_shift_next = tx_shift_reg >> 1;
            end
          end
        end
      end
      default: miso_next = 1'b0;
    endcase
    if (load) begin
      tx_shift_next = buf_full_reg ? buf_reg : '0;
      underrun_next = ~buf_full_reg;
      if (!CPHA) miso_next = buf_full_reg & buf_reg[0];
    end
  end

  // A load in the same cycle as a write takes the old (empty) buffer; the write still lands.
  assign buf_full_next = (buf_full_reg & ~load) | buf_write;
  assign buf_next      = buf_write ? tx_data : buf_reg;

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      bit_cnt_reg   <= '0;
      rx_shift_reg  <= '0;
      tx_shift_reg  <= '0;
      buf_reg       <= '0;
      buf_full_reg  <= 1'b0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      underrun_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      miso_reg      <= 1'b0;
    end else begin
      bit_cnt_reg   <= bit_cnt_next;
      rx_shift_reg  <= rx_shift_next;
      tx_shift_reg  <= tx_shift_next;
      buf_reg       <= buf_next;
      buf_full_reg  <= buf_full_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      underrun_reg  <= underrun_next;
      frame_err_reg <= frame_err_next;
      miso_reg      <= miso_next;
    end
  end

  assign miso0       = miso_reg;
  assign tx_ready    = ~buf_full_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign tx_underrun = underrun_reg;
  assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_spi_slave_shift_engine.sv
// Directed bench: three engines (CPOL0/CPHA0, CPOL1/CPHA0, CPOL0/CPHA1) on one sclk line,
// each with its own chip select, driven by a bench-side SPI master.
module tb_spi_slave_shift_engine;

  localparam int H = 4;

  logic       pclk = 1'b0;
  logic       areset = 1'b0;
  logic       sclk_line = 1'b0;
  logic       sclk_inv;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] cs_a = 2'b11;
  logic [0:0] cs_b = 1'b1;
  logic [0:0] cs_c = 1'b1;
  logic       tx_valid_a = 1'b0, tx_valid_b = 1'b0, tx_valid_c = 1'b0;
  logic       miso_a, miso_b, miso_c;
  logic       tx_ready_a, tx_ready_b, tx_ready_c;
  logic [7:0] rx_data_a, rx_data_b, rx_data_c;
  logic       rx_valid_a, rx_valid_b, rx_valid_c;
  logic       under_a, under_b, under_c;
  logic       ferr_a, ferr_b, ferr_c;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rxv_cnt_a = 0, rxv_cnt_b = 0, rxv_cnt_c = 0;
  int under_cnt_a = 0, under_cnt_b = 0, under_cnt_c = 0;
  int ferr_cnt_a = 0, ferr_cnt_b = 0, ferr_cnt_c = 0;
  int rxv_cyc_a = 0;
  int last_rise_cyc = 0;
  int under_snap = 0;
  logic [7:0] rxd_log_c [2];

  assign sclk_inv = ~sclk_line;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  spi_slave_shift_engine #(.NO_OF_SLAVES(2), .SLAVE_ID(0), .CHAR_LENGTH(8), .CPOL(1'b0), .CPHA(1'b0)) u_a (
    .pclk(pclk), .areset(areset), .sclk(sclk_line), .cs(cs_a), .mosi0(mosi), .miso0(miso_a),
    .tx_data(tx_data), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .tx_underrun(under_a), .frame_err(ferr_a));

  spi_slave_shift_engine #(.NO_OF_SLAVES(1), .SLAVE_ID(0), .CHAR_LENGTH(8), .CPOL(1'b1), .CPHA(1'b0)) u_b (
    .pclk(pclk), .areset(areset), .sclk(sclk_inv), .cs(cs_b), .mosi0(mosi), .miso0(miso_b),
    .tx_data(tx_data), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .tx_underrun(under_b), .frame_err(ferr_b));

  spi_slave_shift_engine #(.NO_OF_SLAVES(1), .SLAVE_ID(0), .CHAR_LENGTH(8), .CPOL(1'b0), .CPHA(1'b1)) u_c (
    .pclk(pclk), .areset(areset), .sclk(sclk_line), .cs(cs_c), .mosi0(mosi), .miso0(miso_c),
    .tx_data(tx_data), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c), .rx_data(rx_data_c),
    .rx_valid(rx_valid_c), .tx_underrun(under_c), .frame_err(ferr_c));

  // Pulse monitors
  always @(negedge pclk) begin
    if (rx_valid_a) begin rxv_cnt_a++; rxv_cyc_a = cyc; end
    if (rx_valid_b) rxv_cnt_b++;
    if (rx_valid_c) begin
      if (rxv_cnt_c < 2) rxd_log_c[rxv_cnt_c] = rx_data_c;
      rxv_cnt_c++;
    end
    if (under_a) under_cnt_a++;
    if (under_b) under_cnt_b++;
    if (under_c) under_cnt_c++;
    if (ferr_a) ferr_cnt_a++;
    if (ferr_b) ferr_cnt_b++;
    if (ferr_c) ferr_cnt_c++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic set_cs(input int inst, input logic v);
    case (inst)
      0: cs_a[0] = v;
      1: cs_b[0] = v;
      default: cs_c[0] = v;
    endcase
  endtask

  function automatic logic get_miso(input int inst);
    case (inst)
      0: return miso_a;
      1: return miso_b;
      default: return miso_c;
    endcase
  endfunction

  function automatic int get_under(input int inst);
    case (inst)
      0: return under_cnt_a;
      1: return under_cnt_b;
      default: return under_cnt_c;
    endcase
  endfunction

  task automatic push(input int inst, input logic [7:0] d);
    tx_data = d;
    case (inst)
      0: tx_valid_a = 1'b1;
      1: tx_valid_b = 1'b1;
      default: tx_valid_c = 1'b1;
    endcase
    wait_cyc(1);
    tx_valid_a = 1'b0; tx_valid_b = 1'b0; tx_valid_c = 1'b0;
  endtask

  // Bench-side master; instance 2 is the CPHA=1 engine. abort_at only applies to instance 0.
  task automatic spi_frame(input int inst, input logic [15:0] mosi_word, input int nbits,
                           input int refill_at, input logic [7:0] refill_word,
                           input int abort_at, output logic [15:0] miso_word);
    bit cpha;
    bit aborted;
    cpha = (inst == 2);
    aborted = 1'b0;
    miso_word = '0;
    set_cs(inst, 1'b0);
    wait_cyc(H);
    for (int i = 0; i < nbits && !aborted; i++) begin
      if (!cpha) mosi = mosi_word[i];
      if (i == refill_at) begin push(inst, refill_word); wait_cyc(H - 1); end
      else wait_cyc(H);
      if (i == abort_at) begin
        areset = 1'b0;
        #1;
        check_eq("abort_miso", 32'(miso_a), 32'h0);
        check_eq("abort_tx_ready", 32'(tx_ready_a), 32'h1);
        check_eq("abort_rx_data", 32'(rx_data_a), 32'h0);
        check_eq("abort_rx_valid", 32'(rx_valid_a), 32'h0);
        check_eq("abort_underrun", 32'(under_a), 32'h0);
        check_eq("abort_frame_err", 32'(ferr_a), 32'h0);
        wait_cyc(1);
        areset = 1'b1;
        set_cs(inst, 1'b1);
        mosi = 1'b0;
        wait_cyc(2 * H);
        aborted = 1'b1;
      end else begin
        if (!cpha) miso_word[i] = get_miso(inst);
        if (i == 0) under_snap = get_under(inst);
        sclk_line = 1'b1;
        last_rise_cyc = cyc;
        if (cpha) mosi = mosi_word[i];
        wait_cyc(H);
        if (cpha) miso_word[i] = get_miso(inst);
        sclk_line = 1'b0;
      end
    end
    if (!aborted) begin
      wait_cyc(H);
      set_cs(inst, 1'b1);
      mosi = 1'b0;
      wait_cyc(2 * H);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mw;
    logic        seen;

    // Reset values while areset is held low
    wait_cyc(3);
    check_eq("rst_miso", 32'(miso_a), 32'h0);
    check_eq("rst_tx_ready", 32'(tx_ready_a), 32'h1);
    check_eq("rst_rx_data", 32'(rx_data_a), 32'h0);
    check_eq("rst_rx_valid", 32'(rx_valid_a), 32'h0);
    check_eq("rst_underrun", 32'(under_a), 32'h0);
    check_eq("rst_frame_err", 32'(ferr_a), 32'h0);
    areset = 1'b1;
    wait_cyc(4);

    // CPOL=0 CPHA=0: buffer 0xA5, receive 0x3C
    push(0, 8'hA5);
    wait_cyc(1);
    check_eq("a_tx_ready_full", 32'(tx_ready_a), 32'h0);
    spi_frame(0, 16'h003C, 8, -1, 8'h00, -1, mw);
    check_eq("a_miso_word", 32'(mw[7:0]), 32'hA5);
    check_eq("a_rx_data", 32'(rx_data_a), 32'h3C);
    check_eq("a_rx_valid_cnt", 32'(rxv_cnt_a), 32'd1);
    check_eq("a_rx_latency", 32'(rxv_cyc_a - last_rise_cyc), 32'd3);
    check_eq("a_tx_ready_after", 32'(tx_ready_a), 32'h1);
    check_eq("a_underrun_wordend", 32'(under_cnt_a), 32'd1);
    check_eq("a_frame_err_cnt", 32'(ferr_cnt_a), 32'd0);
    check_eq("a_miso_idle", 32'(miso_a), 32'h0);

    // CPOL=1 CPHA=0: empty buffer, mosi all ones
    spi_frame(1, 16'h00FF, 8, -1, 8'h00, -1, mw);
    check_eq("b_underrun_at_load", 32'(under_snap), 32'd1);
    check_eq("b_miso_word", 32'(mw[7:0]), 32'h00);
    check_eq("b_rx_data", 32'(rx_data_b), 32'hFF);

    // CPHA=1: back-to-back 0x12, 0x34 with buffer refilled during the first word
    push(2, 8'h5A);
    spi_frame(2, 16'h3412, 16, 3, 8'hC3, -1, mw);
    check_eq("c_miso_words", 32'(mw), 32'hC35A);
    check_eq("c_rx_valid_cnt", 32'(rxv_cnt_c), 32'd2);
    check_eq("c_rx_word0", 32'(rxd_log_c[0]), 32'h12);
    check_eq("c_rx_word1", 32'(rxd_log_c[1]), 32'h34);
    check_eq("c_frame_err_cnt", 32'(ferr_cnt_c), 32'd0);
    check_eq("c_underrun_cnt", 32'(under_cnt_c), 32'd1);

    // cs released after 5 bits
    spi_frame(0, 16'h001F, 5, -1, 8'h00, -1, mw);
    check_eq("e_frame_err_cnt", 32'(ferr_cnt_a), 32'd1);
    check_eq("e_rx_valid_cnt", 32'(rxv_cnt_a), 32'd1);
    check_eq("e_rx_data_kept", 32'(rx_data_a), 32'h3C);
    check_eq("e_miso_idle", 32'(miso_a), 32'h0);

    // areset at bit 3 (tx 0x08 puts a 1 on miso0 there; refill makes tx_ready low)
    push(0, 8'h08);
    spi_frame(0, 16'h00F0, 8, 1, 8'h99, 3, mw);
    check_eq("r_rx_valid_cnt", 32'(rxv_cnt_a), 32'd1);
    check_eq("r_frame_err_cnt", 32'(ferr_cnt_a), 32'd1);
    push(0, 8'h81);
    spi_frame(0, 16'h0081, 8, -1, 8'h00, -1, mw);
    check_eq("r_rx_data", 32'(rx_data_a), 32'h81);
    check_eq("r_miso_word", 32'(mw[7:0]), 32'h81);
    check_eq("r_rx_valid_cnt2", 32'(rxv_cnt_a), 32'd2);

    // Foreign cs bit active with sclk running
    push(0, 8'h77);
    cs_a[1] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      wait_cyc(H);
      seen = seen | miso_a;
      sclk_line = 1'b1;
      wait_cyc(H);
      seen = seen | miso_a;
      sclk_line = 1'b0;
    end
    wait_cyc(H);
    cs_a[1] = 1'b1;
    wait_cyc(8);
    check_eq("o_rx_valid_cnt", 32'(rxv_cnt_a), 32'd2);
    check_eq("o_miso_seen", 32'(seen), 32'h0);
    check_eq("o_tx_ready", 32'(tx_ready_a), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_shift_engine.md
Name: spi_slave_shift_engine

Overview:
- Synthesizable SPI slave data path for one chip-select lane; receives mosi0 and drives miso0.
- Directly consumes the pclk/sclk/cs/areset/mosi0 stimulus that feeds the slave assertion checker, and produces miso0 on the same bus.
- Oversamples sclk, cs and mosi0 on pclk, applies the CPOL/CPHA mode, deserialises received words, and serialises transmit words from a one-entry holding buffer.

Parameters:
- NO_OF_SLAVES, 1, width of the cs bus.
- SLAVE_ID, 0, index of the cs bit this instance responds to.
- CHAR_LENGTH, 8, bits per word; legal range 2..32.
- CPOL, 0, sclk idle level.
- CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.

Ports:
- pclk  in  1  system clock; all logic on rising edge.
- areset  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI serial clock, asynchronous to pclk.
- cs  in  NO_OF_SLAVES  active-low chip selects; only cs[SLAVE_ID] is used.
- mosi0  in  1  serial data from master.
- miso0  out  1  serial data to master.
- tx_data  in  CHAR_LENGTH  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding buffer empty.
- rx_data  out  CHAR_LENGTH  last received word.
- rx_valid  out  1  one-cycle pulse, rx_data updated.
- tx_underrun  out  1  one-cycle pulse, word started with empty buffer.
- frame_err  out  1  one-cycle pulse, cs deasserted mid-word.

Behaviour:
- Reset (areset=0, async) clears everything. Outputs: miso0=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_err=0. State=IDLE, bit_cnt=0, buffer empty.
- Synchronisers: 2-flop on sclk, cs[SLAVE_ID] and mosi0. A third flop on sclk gives registered edge detection.
- Edges: leading edge = synced sclk leaves CPOL; trailing edge = synced sclk returns to CPOL. sample_edge = leading if CPHA=0, else trailing; shift_edge = the other edge.
- Timing requirement: each sclk half-period must be at least 4 pclk cycles. Behaviour below that is undefined.
- Bit order: LSB first. Bit i is transmitted/received in slot i.
- Holding buffer: handshake completes when tx_valid && tx_ready at a pclk edge; the buffer becomes full and tx_ready falls next cycle. The buffer is emptied when a word is loaded into the tx shift register.
- States: IDLE, ACTIVE.
- IDLE:
  - miso0 holds 0.
  - On synced cs falling, load the tx shift register (from buffer if full, else all zeros with a tx_underrun pulse), set bit_cnt=0, go ACTIVE.
  - CPHA=0: miso0 presents bit0 in the same cycle the load happens.
- ACTIVE, sample_edge:
  - rx_shift[bit_cnt] <= synced mosi0; bit_cnt++.
  - When bit_cnt reaches CHAR_LENGTH: rx_data <= assembled word, rx_valid pulses 1 cycle, bit_cnt wraps to 0, tx shift register reloads (buffer or underrun rule).
  - CPHA=0: reloaded bit0 appears on miso0 immediately.
- ACTIVE, shift_edge:
  - CPHA=0: miso0 advances to the next bit, except on the shift_edge following the final sample.
  - CPHA=1: miso0 presents the current bit (bit0 on the first leading edge).
- Latency: rx_valid asserts 3 pclk cycles after the final sample edge reaches the sclk pin (2 sync + 1 capture).
- cs synced rising in ACTIVE:
  - bit_cnt != 0: frame_err pulses, partial word discarded, rx_valid stays 0.
  - Either way: go IDLE, miso0=0.
  - A tx word already loaded is dropped; the buffer is untouched.
- Simultaneous events:
  - Word-end reload and buffer write on the same cycle: the reload takes the old buffer content. If the buffer was empty, the reload is an underrun and the new write lands in the buffer.
  - cs rising together with the final sample edge: the word completes (rx_valid pulse) with no frame_err.
- areset mid-frame: immediate return to reset values; no pulse outputs.

Test Plan:
- Reset, then CPOL=0 CPHA=0. Buffer 0xA5, cs low, master sends 0x3C in 8 sclk cycles (half-period 4 pclk) -> rx_data=0x3C with a single rx_valid pulse 3 cycles after the 8th rising edge; miso0 sequence 1,0,1,0,0,1,0,1; tx_ready high after load.
- CPOL=1 CPHA=0, mosi 0xFF, buffer empty -> tx_underrun pulses once at cs fall; miso0=0 throughout; rx_data=0xFF.
- CPHA=1, two back-to-back words 0x12 then 0x34, buffer refilled between them -> two rx_valid pulses, rx_data 0x12 then 0x34, no frame_err.
- cs raised after 5 bits -> frame_err pulses once, rx_valid stays 0, rx_data retains the previous value, state IDLE, miso0=0.
- areset asserted at bit 3 -> all outputs at reset values within the same cycle; next full frame 0x81 received correctly.
- cs[SLAVE_ID] held high while another cs bit toggles with sclk active -> no rx_valid, miso0=0, tx_ready unchanged.
